// File: rtl/mem_access_arbiter.sv
// Arbiter and sequencer for the shared memory port: fetch (F), data (D) and debug (G).
// Each access becomes one strobe, a fixed-latency wait and a one-cycle ack pulse.
module mem_access_arbiter #(
   parameter int MEM_LAT      = 1,
   parameter int STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_halt,
   input  logic        f_req,
   input  logic [15:0] f_addr,
   output logic        f_ack,
   output logic [15:0] f_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic        d_byte,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic        d_ack,
   output logic [15:0] d_rdata,
   output logic        d_err,
   input  logic        g_req,
   input  logic [15:0] g_addr,
   output logic        g_ack,
   output logic [15:0] g_rdata,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic        mem_byte,
   input  logic [15:0] mem_rdata,
   output logic        busy,
   output logic [1:0]  grant,
   output logic [1:0]  dbg_state
);

   // Handshake: each req is a level held until its ack; ack is a single-cycle
   // pulse and the matching rdata/err are valid only while that ack is high.

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_F    = 2'd1;
   localparam logic [1:0] OWN_D    = 2'd2;
   localparam logic [1:0] OWN_G    = 2'd3;

   localparam logic [2:0] WAIT_INIT  = 3'(MEM_LAT - 1);
   localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

   state_t      state;
   logic [1:0]  owner;
   logic [15:0] l_addr;
   logic        l_we;
   logic        l_byte;
   logic        l_fault;
   logic [2:0]  wait_cnt;
   logic [7:0]  starve_cnt;

   logic [1:0]  win;
   logic        starved;
   logic [15:0] w_addr;
   logic [15:0] w_wdata;
   logic        w_we;
   logic        w_byte;
   logic        w_fault;
   logic [15:0] rd_data;

   assign dbg_state = state;

   always_comb begin
      starved = g_req && (starve_cnt >= STARVE_MAX);
      win     = OWN_NONE;
      if (starved)
         win = OWN_G;
      else if (cpu_halt) begin
         if (g_req)      win = OWN_G;
         else if (d_req) win = OWN_D;
         else if (f_req) win = OWN_F;
      end else begin
         if (d_req)      win = OWN_D;
         else if (f_req) win = OWN_F;
         else if (g_req) win = OWN_G;
      end
   end

   // F and G are always word reads; only D carries we/byte/wdata.
   always_comb begin
      w_addr  = 16'h0000;
      w_wdata = 16'h0000;
      w_we    = 1'b0;
      w_byte  = 1'b0;
      case (win)
         OWN_F: w_addr = f_addr;
         OWN_D: begin
            w_addr  = d_addr;
            w_wdata = d_wdata;
            w_we    = d_we;
            w_byte  = d_byte;
         end
         OWN_G: w_addr = g_addr;
         default: ;
      endcase
      w_fault = (win == OWN_D) && !d_byte && d_addr[0];
   end

   always_comb begin
      rd_data = mem_rdata;
      if (l_byte)
         rd_data = l_addr[0] ? {8'h00, mem_rdata[15:8]} : {8'h00, mem_rdata[7:0]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         owner      <= OWN_NONE;
         l_addr     <= 16'h0000;
         l_we       <= 1'b0;
         l_byte     <= 1'b0;
         l_fault    <= 1'b0;
         wait_cnt   <= 3'd0;
         starve_cnt <= 8'd0;
         f_ack      <= 1'b0;
         f_rdata    <= 16'h0000;
         d_ack      <= 1'b0;
         d_rdata    <= 16'h0000;
         d_err      <= 1'b0;
         g_ack      <= 1'b0;
         g_rdata    <= 16'h0000;
         mem_addr   <= 16'h0000;
         mem_wdata  <= 16'h0000;
         mem_rd     <= 1'b0;
         mem_wr     <= 1'b0;
         mem_byte   <= 1'b0;
         busy       <= 1'b0;
         grant      <= OWN_NONE;
      end else begin
         if (!g_req)
            starve_cnt <= 8'd0;
         else if (state == S_IDLE) begin
            if (win == OWN_G)
               starve_cnt <= 8'd0;
            else if (starve_cnt != 8'hFF)
               starve_cnt <= starve_cnt + 8'd1;
         end

         case (state)
            S_IDLE: begin
               if (win != OWN_NONE) begin
                  state     <= S_ISSUE;
                  owner     <= win;
                  grant     <= win;
                  busy      <= 1'b1;
                  l_addr    <= w_addr;
                  l_we      <= w_we;
                  l_byte    <= w_byte;
                  l_fault   <= w_fault;
                  mem_addr  <= w_byte ? w_addr : {w_addr[15:1], 1'b0};
                  mem_byte  <= w_byte;
                  mem_wdata <= !w_we ? 16'h0000 :
                               (w_byte ? {w_wdata[7:0], w_wdata[7:0]} : w_wdata);
                  mem_rd    <= !w_we && !w_fault;
                  mem_wr    <= w_we && !w_fault;
               end
            end
            S_ISSUE: begin
               mem_addr  <= 16'h0000;
               mem_wdata <= 16'h0000;
               mem_rd    <= 1'b0;
               mem_wr    <= 1'b0;
               mem_byte  <= 1'b0;
               // Writes and faults complete without waiting on the memory.
               if (l_we || l_fault) begin
                  state <= S_DONE;
                  d_ack <= (owner == OWN_D);
                  d_err <= l_fault;
               end else begin
                  state    <= S_WAIT;
                  wait_cnt <= WAIT_INIT;
               end
            end
            S_WAIT: begin
               if (wait_cnt == 3'd0) begin
                  state <= S_DONE;
                  case (owner)
                     OWN_F: begin
                        f_ack   <= 1'b1;
                        f_rdata <= rd_data;
                     end
                     OWN_D: begin
                        d_ack   <= 1'b1;
                        d_rdata <= rd_data;
                     end
                     OWN_G: begin
                        g_ack   <= 1'b1;
                        g_rdata <= rd_data;
                     end
                     default: ;
                  endcase
               end else begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end
            S_DONE: begin
               state   <= S_IDLE;
               owner   <= OWN_NONE;
               grant   <= OWN_NONE;
               busy    <= 1'b0;
               f_ack   <= 1'b0;
               f_rdata <= 16'h0000;
               d_ack   <= 1'b0;
               d_rdata <= 16'h0000;
               d_err   <= 1'b0;
               g_ack   <= 1'b0;
               g_rdata <= 16'h0000;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=4.
// Both see the same requester inputs; each has its own memory model.
module tb_mem_access_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_halt = 1'b0;
   logic        f_req = 1'b0;
   logic [15:0] f_addr = 16'h0000;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic        d_byte = 1'b0;
   logic [15:0] d_addr = 16'h0000;
   logic [15:0] d_wdata = 16'h0000;
   logic        g_req = 1'b0;
   logic [15:0] g_addr = 16'h0000;

   logic        f_ack, d_ack, d_err, g_ack, mem_rd, mem_wr, mem_byte, busy;
   logic [15:0] f_rdata, d_rdata, g_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  grant, dbg_state;

   logic        f_ack_4, d_ack_4, d_err_4, g_ack_4, mem_rd_4, mem_wr_4, mem_byte_4, busy_4;
   logic [15:0] f_rdata_4, d_rdata_4, g_rdata_4, mem_addr_4, mem_wdata_4, mem_rdata_4;
   logic [1:0]  grant_4, dbg_state_4;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] rd_base = 16'h0000;

   // clock / reset
   always #5 clk = ~clk;

   mem_access_arbiter #(.MEM_LAT(1), .STARVE_LIMIT(8)) u_dut (
      .clk(clk), .rst(rst), .cpu_halt(cpu_halt),
      .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
      .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
      .g_req(g_req), .g_addr(g_addr), .g_ack(g_ack), .g_rdata(g_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_byte(mem_byte), .mem_rdata(mem_rdata),
      .busy(busy), .grant(grant), .dbg_state(dbg_state)
   );

   mem_access_arbiter #(.MEM_LAT(4), .STARVE_LIMIT(8)) u_dut_4 (
      .clk(clk), .rst(rst), .cpu_halt(cpu_halt),
      .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack_4), .f_rdata(f_rdata_4),
      .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack_4), .d_rdata(d_rdata_4), .d_err(d_err_4),
      .g_req(g_req), .g_addr(g_addr), .g_ack(g_ack_4), .g_rdata(g_rdata_4),
      .mem_addr(mem_addr_4), .mem_wdata(mem_wdata_4), .mem_rd(mem_rd_4), .mem_wr(mem_wr_4),
      .mem_byte(mem_byte_4), .mem_rdata(mem_rdata_4),
      .busy(busy_4), .grant(grant_4), .dbg_state(dbg_state_4)
   );

   // Latency-1 memory; unwritten words read as rd_base ^ aligned address.
   logic [15:0] mem_arr [0:511];
   bit          mem_vld [0:511];
   logic [15:0] mem_w;
   logic [8:0]  mem_idx;
   assign mem_idx = mem_addr[9:1];

   always @(posedge clk) begin
      if (mem_wr) begin
         mem_w = mem_vld[mem_idx] ? mem_arr[mem_idx] : (rd_base ^ {mem_addr[15:1], 1'b0});
         if (!mem_byte)
            mem_w = mem_wdata;
         else if (mem_addr[0])
            mem_w[15:8] = mem_wdata[15:8];
         else
            mem_w[7:0] = mem_wdata[7:0];
         mem_arr[mem_idx] <= mem_w;
         mem_vld[mem_idx] <= 1'b1;
      end
      if (mem_rd)
         mem_rdata <= mem_vld[mem_idx] ? mem_arr[mem_idx] : (rd_base ^ {mem_addr[15:1], 1'b0});
      else
         mem_rdata <= 16'hDEAD;
   end

   // Latency-4 memory returning the inverted address.
   logic [15:0] pipe_4 [0:3];
   always @(posedge clk) begin
      pipe_4[0] <= mem_rd_4 ? ~mem_addr_4 : 16'hDEAD;
      for (int i = 1; i < 4; i++) pipe_4[i] <= pipe_4[i-1];
   end
   assign mem_rdata_4 = pipe_4[3];

   initial begin
      #400000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({f_ack, d_ack, g_ack, d_err, mem_rd, mem_wr, mem_byte, busy, grant, dbg_state} !== 12'h000) begin
         errors++;
         $display("FAIL reset_ctrl got=%b exp=0", {f_ack, d_ack, g_ack, d_err, mem_rd, mem_wr, mem_byte, busy, grant, dbg_state});
      end
      checks++;
      if ({mem_addr, mem_wdata, f_rdata, d_rdata, g_rdata} !== 80'h0) begin
         errors++;
         $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, f_rdata, d_rdata, g_rdata});
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({busy, grant, mem_rd, mem_wr, busy_4, grant_4} !== 8'h00) begin
         errors++;
         $display("FAIL reset_idle got=%b exp=0", {busy, grant, mem_rd, mem_wr, busy_4, grant_4});
      end
   endtask

   task automatic test_fetch;
      rd_base = 16'hAACD;
      f_addr  = 16'h0101;
      f_req   = 1'b1;
      tick();
      checks++;
      if ({mem_rd, mem_wr, grant, busy, f_ack} !== 6'b10_01_1_0 || mem_addr !== 16'h0100) begin
         errors++;
         $display("FAIL fetch_issue got=%b addr=%h exp=100110 addr=0100", {mem_rd, mem_wr, grant, busy, f_ack}, mem_addr);
      end
      tick();
      checks++;
      if ({mem_rd, f_ack, grant} !== 4'b0_0_01) begin
         errors++;
         $display("FAIL fetch_wait got=%b exp=0001", {mem_rd, f_ack, grant});
      end
      tick();
      checks++;
      if (f_ack !== 1'b1 || f_rdata !== 16'hABCD || grant !== 2'd1) begin
         errors++;
         $display("FAIL fetch_ack got=%b data=%h grant=%0d exp=1 data=abcd grant=1", f_ack, f_rdata, grant);
      end
      f_req = 1'b0;
      tick();
      checks++;
      if ({f_ack, grant, busy} !== 4'b0) begin
         errors++;
         $display("FAIL fetch_idle got=%b exp=0", {f_ack, grant, busy});
      end
   endtask

   task automatic test_normal_priority;
      int          n_ack = 0;
      int          ack_k [3] = '{-1, -1, -1};
      logic [1:0]  order [3] = '{2'd0, 2'd0, 2'd0};
      logic [15:0] data  [3] = '{16'h0, 16'h0, 16'h0};
      rd_base  = 16'h0000;
      cpu_halt = 1'b0;
      f_addr   = 16'h0110;
      g_addr   = 16'h0421;
      d_addr   = 16'h0200;
      d_we     = 1'b0;
      d_byte   = 1'b0;
      f_req    = 1'b1;
      d_req    = 1'b1;
      g_req    = 1'b1;
      for (int k = 0; k < 40 && n_ack < 3; k++) begin
         tick();
         checks++;
         if ((int'(f_ack) + int'(d_ack) + int'(g_ack)) > 1 || (mem_rd && mem_wr)) begin
            errors++;
            $display("FAIL prio_overlap acks=%b strobes=%b exp=at most one", {f_ack, d_ack, g_ack}, {mem_rd, mem_wr});
         end
         if (d_ack) begin
            order[n_ack] = 2'd2; data[n_ack] = d_rdata; ack_k[n_ack] = k; n_ack++; d_req = 1'b0;
         end else if (f_ack) begin
            order[n_ack] = 2'd1; data[n_ack] = f_rdata; ack_k[n_ack] = k; n_ack++; f_req = 1'b0;
         end else if (g_ack) begin
            order[n_ack] = 2'd3; data[n_ack] = g_rdata; ack_k[n_ack] = k; n_ack++; g_req = 1'b0;
         end
      end
      f_req = 1'b0; d_req = 1'b0; g_req = 1'b0;
      checks++;
      if ({order[0], order[1], order[2]} !== 6'b10_01_11) begin
         errors++;
         $display("FAIL prio_order got=%b (n=%0d) exp=100111", {order[0], order[1], order[2]}, n_ack);
      end
      checks++;
      if (ack_k[0] != 2 || ack_k[1] != 6 || ack_k[2] != 10) begin
         errors++;
         $display("FAIL prio_timing got=%0d,%0d,%0d exp=2,6,10", ack_k[0], ack_k[1], ack_k[2]);
      end
      checks++;
      if (data[0] !== 16'h0200 || data[1] !== 16'h0110 || data[2] !== 16'h0420) begin
         errors++;
         $display("FAIL prio_data got=%h,%h,%h exp=0200,0110,0420", data[0], data[1], data[2]);
      end
      tick();
   endtask

   task automatic test_byte_write_read;
      logic [15:0] rd_addr [2] = '{16'h0301, 16'h0300};
      logic [15:0] rd_exp  [2] = '{16'h0034, 16'h00C7};
      rd_base = 16'h00C7;
      d_we    = 1'b1;
      d_byte  = 1'b1;
      d_addr  = 16'h0301;
      d_wdata = 16'h1234;
      d_req   = 1'b1;
      tick();
      checks++;
      if ({mem_wr, mem_rd, mem_byte, grant} !== 5'b1_0_1_10 || mem_wdata !== 16'h3434 || mem_addr !== 16'h0301) begin
         errors++;
         $display("FAIL bwrite_issue got=%b wdata=%h addr=%h exp=10110 wdata=3434 addr=0301", {mem_wr, mem_rd, mem_byte, grant}, mem_wdata, mem_addr);
      end
      tick();
      checks++;
      if ({d_ack, d_err, mem_wr} !== 3'b100) begin
         errors++;
         $display("FAIL bwrite_ack got=%b exp=100", {d_ack, d_err, mem_wr});
      end
      d_req = 1'b0;
      tick();
      for (int i = 0; i < 2; i++) begin
         d_we   = 1'b0;
         d_addr = rd_addr[i];
         d_req  = 1'b1;
         tick();
         checks++;
         if ({mem_rd, mem_byte} !== 2'b11 || mem_addr !== rd_addr[i]) begin
            errors++;
            $display("FAIL bread_issue[%0d] got=%b addr=%h exp=11 addr=%h", i, {mem_rd, mem_byte}, mem_addr, rd_addr[i]);
         end
         tick();
         tick();
         checks++;
         if (d_ack !== 1'b1 || d_rdata !== rd_exp[i]) begin
            errors++;
            $display("FAIL bread_data[%0d] got=%b/%h exp=1/%h", i, d_ack, d_rdata, rd_exp[i]);
         end
         d_req = 1'b0;
         tick();
      end
      d_byte = 1'b0;
   endtask

   task automatic test_fault;
      for (int we = 0; we < 2; we++) begin
         d_we    = we[0];
         d_byte  = 1'b0;
         d_addr  = 16'h0005;
         d_wdata = 16'hFFFF;
         d_req   = 1'b1;
         tick();
         checks++;
         if ({mem_rd, mem_wr, grant, busy} !== 5'b00_10_1) begin
            errors++;
            $display("FAIL fault_issue[%0d] got=%b exp=00101", we, {mem_rd, mem_wr, grant, busy});
         end
         tick();
         checks++;
         if ({d_ack, d_err, mem_rd, mem_wr} !== 4'b1100 || d_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL fault_ack[%0d] got=%b data=%h exp=1100 data=0000", we, {d_ack, d_err, mem_rd, mem_wr}, d_rdata);
         end
         d_req = 1'b0;
         tick();
         checks++;
         if ({d_ack, d_err, busy} !== 3'b000) begin
            errors++;
            $display("FAIL fault_end[%0d] got=%b exp=000", we, {d_ack, d_err, busy});
         end
      end
      d_we = 1'b0;
   endtask

   task automatic test_halt_priority;
      int g_k = -1;
      int f_k = -1;
      rd_base  = 16'h0000;
      cpu_halt = 1'b1;
      g_addr   = 16'h0500;
      f_addr   = 16'h0601;
      g_req    = 1'b1;
      f_req    = 1'b1;
      for (int k = 0; k < 30 && f_k < 0; k++) begin
         tick();
         if (k == 0) begin
            checks++;
            if (grant !== 2'd3 || mem_addr !== 16'h0500) begin
               errors++;
               $display("FAIL halt_grant got=%0d addr=%h exp=3 addr=0500", grant, mem_addr);
            end
         end
         if (g_ack) begin
            g_k = k;
            g_req = 1'b0;
            checks++;
            if (g_rdata !== 16'h0500) begin
               errors++;
               $display("FAIL halt_gdata got=%h exp=0500", g_rdata);
            end
         end
         if (f_ack) begin
            f_k = k;
            f_req = 1'b0;
            checks++;
            if (f_rdata !== 16'h0600) begin
               errors++;
               $display("FAIL halt_fdata got=%h exp=0600", f_rdata);
            end
         end
      end
      g_req = 1'b0; f_req = 1'b0;
      checks++;
      if (g_k != 2 || f_k != 6) begin
         errors++;
         $display("FAIL halt_order got=g%0d,f%0d exp=g2,f6", g_k, f_k);
      end
      cpu_halt = 1'b0;
      tick();
   endtask

   task automatic test_starvation;
      int  n_f   = 0;
      bit  got_g = 1'b0;
      cpu_halt = 1'b0;
      f_addr   = 16'h0700;
      g_addr   = 16'h0800;
      f_req    = 1'b1;
      g_req    = 1'b1;
      for (int k = 0; k < 200 && !got_g; k++) begin
         tick();
         if (f_ack) n_f++;
         if (g_ack) begin
            got_g = 1'b1;
            checks++;
            if (g_rdata !== 16'h0800) begin
               errors++;
               $display("FAIL starve_gdata got=%h exp=0800", g_rdata);
            end
         end
      end
      f_req = 1'b0; g_req = 1'b0;
      checks++;
      if (!got_g || n_f != 8) begin
         errors++;
         $display("FAIL starve_count got=g%0d after %0d fetches exp=g1 after 8", got_g, n_f);
      end
      tick();
      tick();
   endtask

   task automatic test_reset_mid_read;
      int n_bad = 0;
      int ack_k = -1;
      rst = 1'b1;
      tick();
      rst    = 1'b0;
      f_addr = 16'h0042;
      f_req  = 1'b1;
      tick();
      checks++;
      if (mem_rd_4 !== 1'b1 || mem_addr_4 !== 16'h0042) begin
         errors++;
         $display("FAIL rst4_issue got=%b addr=%h exp=1 addr=0042", mem_rd_4, mem_addr_4);
      end
      tick();
      tick();
      checks++;
      if (dbg_state_4 !== 2'd2 || busy_4 !== 1'b1) begin
         errors++;
         $display("FAIL rst4_inwait got=state%0d busy%b exp=state2 busy1", dbg_state_4, busy_4);
      end
      rst   = 1'b1;
      f_req = 1'b0;
      tick();
      checks++;
      if ({f_ack_4, d_ack_4, g_ack_4, d_err_4, mem_rd_4, mem_wr_4, mem_byte_4, busy_4, grant_4, dbg_state_4} !== 12'h000 ||
          {mem_addr_4, mem_wdata_4, f_rdata_4} !== 48'h0) begin
         errors++;
         $display("FAIL rst4_outputs got=%b/%h exp=0", {f_ack_4, d_ack_4, g_ack_4, mem_rd_4, mem_wr_4, busy_4, grant_4, dbg_state_4}, {mem_addr_4, mem_wdata_4, f_rdata_4});
      end
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (f_ack_4 || busy_4) n_bad++;
      end
      checks++;
      if (n_bad != 0) begin
         errors++;
         $display("FAIL rst4_noack got=%0d active cycles exp=0", n_bad);
      end
      f_req = 1'b1;
      for (int k = 0; k < 20 && ack_k < 0; k++) begin
         tick();
         if (f_ack_4) begin
            ack_k = k;
            f_req = 1'b0;
            checks++;
            if (f_rdata_4 !== 16'hFFBD) begin
               errors++;
               $display("FAIL rst4_data got=%h exp=ffbd", f_rdata_4);
            end
         end
      end
      f_req = 1'b0;
      checks++;
      if (ack_k != 5) begin
         errors++;
         $display("FAIL rst4_latency got=%0d exp=5", ack_k);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_normal_priority();
      test_byte_write_read();
      test_fault();
      test_halt_priority();
      test_starvation();
      test_reset_mid_read();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
